// File: rtl/ps2_scancode_queue_if.sv
// Scancode-queue bus: decoder byte stream in, CPU-side FIFO read/status and modifier state out.
// slave modport is the queue itself; master is whoever drives bytes and pops entries.
interface ps2_scancode_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          code_valid;
    logic [7:0]    code_data;
    logic          rd_en;
    logic [9:0]    rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          ovf_clear;
    logic          irq;
    logic          mod_shift;
    logic          mod_ctrl;
    logic          mod_alt;

    modport master (
        output code_valid, code_data, rd_en, ovf_clear,
        input  rd_data, empty, full, count, overflow, irq, mod_shift, mod_ctrl, mod_alt
    );

    modport slave (
        input  code_valid, code_data, rd_en, ovf_clear,
        output rd_data, empty, full, count, overflow, irq, mod_shift, mod_ctrl, mod_alt
    );
endinterface

// File: rtl/ps2_scancode_queue.sv
// Set-2 scancode prefix stripper + modifier tracker feeding a FWFT event FIFO; 1-cycle byte-to-head latency.
// No backpressure to the decoder: events arriving while full (without a same-cycle pop) are dropped and flagged.
module ps2_scancode_queue #(
    parameter int DEPTH          = 8,
    parameter int PREFIX_TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               reset,
    ps2_scancode_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } evt_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
    evt_t          evt;
    logic          evt_vld;
    logic          is_discard;

    logic shift_l, shift_r, ctrl_l, ctrl_r, alt_l, alt_r;

    evt_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          empty, full;
    logic          push, pop, drop;

    always_comb begin
        case (bus.code_data)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_discard = 1'b1;
            default:                                                 is_discard = 1'b0;
        endcase
    end

    // A second prefix after F0 is malformed and abandons the sequence silently.
    always_comb begin
        state_nxt = state;
        evt_vld   = 1'b0;
        evt.brk   = (state == BRK) || (state == EXT_BRK);
        evt.ext   = (state == EXT) || (state == EXT_BRK);
        evt.code  = bus.code_data;
        if (bus.code_valid) begin
            if (bus.code_data == 8'hE0) begin
                state_nxt = (state == IDLE || state == EXT) ? EXT : IDLE;
            end else if (bus.code_data == 8'hF0) begin
                case (state)
                    IDLE:    state_nxt = BRK;
                    EXT:     state_nxt = EXT_BRK;
                    default: state_nxt = IDLE;
                endcase
            end else begin
                state_nxt = IDLE;
                evt_vld   = !is_discard;
            end
        end else if (state != IDLE && tmo_cnt == TW'(PREFIX_TIMEOUT - 1)) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        tmo_cnt_nxt = tmo_cnt + TW'(1);
        if (bus.code_valid || state_nxt == IDLE) begin
            tmo_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
        end
    end

    // Modifiers track every formed event, even one the FIFO has to drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            ctrl_l  <= 1'b0;
            ctrl_r  <= 1'b0;
            alt_l   <= 1'b0;
            alt_r   <= 1'b0;
        end else if (evt_vld) begin
            if (!evt.ext && evt.code == 8'h12) shift_l <= !evt.brk;
            if (!evt.ext && evt.code == 8'h59) shift_r <= !evt.brk;
            if (!evt.ext && evt.code == 8'h14) ctrl_l  <= !evt.brk;
            if ( evt.ext && evt.code == 8'h14) ctrl_r  <= !evt.brk;
            if (!evt.ext && evt.code == 8'h11) alt_l   <= !evt.brk;
            if ( evt.ext && evt.code == 8'h11) alt_r   <= !evt.brk;
        end
    end

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign pop   = bus.rd_en && !empty;
    assign push  = evt_vld && (!full || bus.rd_en);
    assign drop  = evt_vld && full && !bus.rd_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // When full with a same-cycle pop, the write slot is the head being consumed this edge.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.overflow <= 1'b0;
        end else if (drop) begin
            bus.overflow <= 1'b1;
        end else if (bus.ovf_clear) begin
            bus.overflow <= 1'b0;
        end
    end

    assign bus.rd_data   = empty ? 10'd0 : mem[rd_ptr];
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.count     = cnt;
    assign bus.irq       = !empty;
    assign bus.mod_shift = shift_l | shift_r;
    assign bus.mod_ctrl  = ctrl_l | ctrl_r;
    assign bus.mod_alt   = alt_l | alt_r;
endmodule

// File: tb/tb_ps2_scancode_queue.sv
// Directed bench for ps2_scancode_queue: expected FIFO entries go into a scoreboard queue, a monitor checks every pop.
module tb_ps2_scancode_queue;
    localparam int DEPTH = 8;
    localparam int TMO   = 1000;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    ps2_scancode_queue_if #(.DEPTH(DEPTH)) bus ();

    ps2_scancode_queue #(.DEPTH(DEPTH), .PREFIX_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Byte is sampled at the next rising edge; returns 1 time unit after that edge.
    task automatic send(input logic [7:0] b, input logic rd = 1'b0, input logic clr = 1'b0);
        bus.code_valid = 1'b1;
        bus.code_data  = b;
        bus.rd_en      = rd;
        bus.ovf_clear  = clr;
        @(posedge clk);
        #1;
        bus.code_valid = 1'b0;
        bus.rd_en      = 1'b0;
        bus.ovf_clear  = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        bus.rd_en = 1'b1;
        while (!bus.empty && guard < 2 * DEPTH) begin
            @(posedge clk);
            #1;
            guard++;
        end
        bus.rd_en = 1'b0;
        check("drain_empty", {31'd0, bus.empty}, 32'd1);
        check("scoreboard_left", exp_q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.rd_en && !bus.empty) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got %03h, expected no entry", bus.rd_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (bus.rd_data !== e) begin
                    n_bad++;
                    $display("FAIL pop_data: got %03h, expected %03h", bus.rd_data, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.code_valid = 1'b0;
        bus.code_data  = 8'h00;
        bus.rd_en      = 1'b0;
        bus.ovf_clear  = 1'b0;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_irq", bus.irq, 0);
        check("rst_mods", {bus.mod_shift, bus.mod_ctrl, bus.mod_alt}, 0);

        // Plain make then break, with idle gaps between bytes
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(10'h01C);
        send(8'h1C);
        check("t1_count1", bus.count, 1);
        check("t1_irq", bus.irq, 1);
        check("t1_head", bus.rd_data, 10'h01C);
        repeat (2) @(posedge clk);
        #1;
        send(8'hF0);
        check("t1_count_after_f0", bus.count, 1);
        exp_q.push_back(10'h21C);
        send(8'h1C);
        check("t1_count2", bus.count, 2);
        drain();

        // Extended make and extended break
        exp_q.push_back(10'h175);
        send(8'hE0); send(8'h75);
        exp_q.push_back(10'h375);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("t2_count", bus.count, 2);
        drain();

        // Modifier tracking
        exp_q.push_back(10'h012);
        send(8'h12);
        check("t3_shift_make", bus.mod_shift, 1);
        exp_q.push_back(10'h114);
        send(8'hE0); send(8'h14);
        check("t3_ctrl_make", bus.mod_ctrl, 1);
        exp_q.push_back(10'h212);
        send(8'hF0); send(8'h12);
        check("t3_shift_break", bus.mod_shift, 0);
        check("t3_ctrl_held", bus.mod_ctrl, 1);
        exp_q.push_back(10'h112);
        send(8'hE0); send(8'h12);
        check("t3_ext12_ignored", bus.mod_shift, 0);
        exp_q.push_back(10'h059);
        send(8'h59);
        check("t3_rshift_make", bus.mod_shift, 1);
        exp_q.push_back(10'h259);
        send(8'hF0); send(8'h59);
        check("t3_rshift_break", bus.mod_shift, 0);
        drain();
        exp_q.push_back(10'h011);
        send(8'h11);
        check("t3_alt_make", bus.mod_alt, 1);
        exp_q.push_back(10'h311);
        send(8'hE0); send(8'hF0); send(8'h11);
        check("t3_alt_left_held", bus.mod_alt, 1);
        exp_q.push_back(10'h211);
        send(8'hF0); send(8'h11);
        check("t3_alt_break", bus.mod_alt, 0);
        exp_q.push_back(10'h014);
        send(8'h14);
        exp_q.push_back(10'h314);
        send(8'hE0); send(8'hF0); send(8'h14);
        check("t3_ctrl_left_held", bus.mod_ctrl, 1);
        exp_q.push_back(10'h214);
        send(8'hF0); send(8'h14);
        check("t3_ctrl_break", bus.mod_ctrl, 0);
        drain();

        // Prefix timeout: expires after TMO idle cycles, last usable cycle is TMO-1
        exp_q.push_back(10'h01C);
        send(8'hE0);
        repeat (TMO) @(posedge clk);
        #1;
        send(8'h1C);
        check("t4_timeout_head", bus.rd_data, 10'h01C);
        exp_q.push_back(10'h11C);
        send(8'hE0);
        repeat (TMO - 2) @(posedge clk);
        #1;
        send(8'h1C);
        drain();

        // Fill, overflow, push+pop while full, clear/drop race
        for (int b = 8'h15; b <= 8'h1D; b++) begin
            if (b <= 8'h1C) exp_q.push_back(10'(b));
            send(8'(b));
        end
        check("t5_full", bus.full, 1);
        check("t5_count", bus.count, DEPTH);
        check("t5_overflow", bus.overflow, 1);
        check("t5_head", bus.rd_data, 10'h015);
        exp_q.push_back(10'h01E);
        send(8'h1E, 1'b1);
        check("t5_count_pushpop", bus.count, DEPTH);
        check("t5_head_after_pop", bus.rd_data, 10'h016);
        send(8'h1F, 1'b0, 1'b1);
        check("t5_ovf_clear_vs_drop", bus.overflow, 1);
        send(8'h12);
        check("t5_mod_on_drop", bus.mod_shift, 1);
        send(8'hF0); send(8'h12);
        check("t5_mod_break_on_drop", bus.mod_shift, 0);
        bus.ovf_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.ovf_clear = 1'b0;
        check("t5_ovf_cleared", bus.overflow, 0);
        check("t5_count_kept", bus.count, DEPTH);
        drain();

        // Discard bytes and malformed prefixes
        send(8'hAA); send(8'hFA);
        check("t6_discard_count", bus.count, 0);
        send(8'hF0); send(8'hF0);
        check("t6_f0f0_count", bus.count, 0);
        exp_q.push_back(10'h01C);
        send(8'h1C);
        exp_q.push_back(10'h01C);
        send(8'hE0); send(8'hAA); send(8'h1C);
        check("t6_count", bus.count, 2);
        drain();

        // Reset in the middle of a prefix sequence
        send(8'h59);
        send(8'hE0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t7_rst_count", bus.count, 0);
        check("t7_rst_shift", bus.mod_shift, 0);
        exp_q.push_back(10'h01C);
        send(8'h1C);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
